// File: rtl/fb_scanout.sv
// Framebuffer scan-out: fetches one 32-bit word per row from the RAM pixel port
// and serialises it LSB-first as a valid/ready pixel stream with frame framing.
module fb_scanout #(
   parameter logic [7:0] BASE_WORD  = 8'd192,
   parameter int         HEIGHT     = 32,
   parameter int         GAP_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [9:0]  pixelAddress,
   input  logic [31:0] pixel_out,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_data,
   output logic [4:0]  pix_x,
   output logic [7:0]  pix_y,
   output logic        sof,
   output logic        eol,
   output logic        frame_done
);
   localparam int         GW   = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
   localparam logic [7:0] LAST = 8'(HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} state_t;

   state_t         state, state_nx;
   logic [7:0]     row, row_nx;
   logic [4:0]     x, x_nx;
   logic [31:0]    shreg, shreg_nx;
   logic [GW-1:0]  gcnt, gcnt_nx;
   logic           done, done_nx;
   logic [7:0]     word;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         row   <= '0;
         x     <= '0;
         shreg <= '0;
         gcnt  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         row   <= row_nx;
         x     <= x_nx;
         shreg <= shreg_nx;
         gcnt  <= gcnt_nx;
         done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      row_nx   = row;
      x_nx     = x;
      shreg_nx = shreg;
      gcnt_nx  = gcnt;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               row_nx   = '0;
               state_nx = FETCH;
            end
         end
         FETCH: begin
            shreg_nx = pixel_out;
            x_nx     = '0;
            state_nx = SHIFT;
         end
         SHIFT: begin
            if (pix_ready) begin
               if (x != 5'd31) begin
                  x_nx = x + 5'd1;
               end else if (row != LAST) begin
                  row_nx   = row + 8'd1;
                  state_nx = FETCH;
               end else begin
                  // row returns to 0 so IDLE/GAP present the row-0 address
                  row_nx   = '0;
                  done_nx  = 1'b1;
                  gcnt_nx  = '0;
                  state_nx = GAP;
               end
            end
         end
         GAP: begin
            if (gcnt == GW'(GAP_CYCLES)) begin
               row_nx   = '0;
               state_nx = enable ? FETCH : IDLE;
            end else begin
               gcnt_nx = gcnt + GW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Address is forced to zero while reset is held, not just after the edge
   assign word         = BASE_WORD + row;
   assign pixelAddress = reset ? 10'd0 : {word, 2'b00};
   assign pix_valid    = (state == SHIFT);
   assign pix_data     = pix_valid & shreg[x];
   assign pix_x        = pix_valid ? x : 5'd0;
   assign pix_y        = pix_valid ? row : 8'd0;
   assign sof          = pix_valid && (x == 5'd0) && (row == 8'd0);
   assign eol          = pix_valid && (x == 5'd31);
   assign frame_done   = done;
endmodule
